chan_arbiter: RTL and testbench

CHAN_ARBITER -- requirements
Module: chan_arbiter

---
 rtl/chan_arbiter.sv | 149 ++++++++++++++
 tb/tb_chan_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_arbiter.sv
// chan_arbiter: round-robin merger of NCH channel block FIFOs onto a single 16-bit word stream.
// Optional macro CHKHDR_EN: reject header words whose bit 15 is clear (one-cycle err pulse).
module chan_arbiter #(
  parameter int NCH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  output logic [NCH-1:0]    ack,
  input  logic [16*NCH-1:0] din,
  output logic [15:0]       odata,
  output logic              ovalid,
  input  logic              ofull,
  output logic              err
);
  localparam int          CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned NCHU = NCH;

  typedef enum logic [2:0] {IDLE, HDR, DEC, COPY, GAP} state_t;

  state_t         r_state, w_state;
  logic [CW-1:0]  r_ch, w_ch;
  logic [8:0]     r_rem, w_rem;
  logic [NCH-1:0] r_ack, w_ack;
  logic           r_take;
  logic           r_excl, w_excl;
  logic [15:0]    r_odata, w_odata;
  logic           r_ovalid, w_ovalid;
  logic           w_hit;
  logic [CW-1:0]  w_pick, w_idx;
  logic [15:0]    w_word;
  logic [8:0]     w_hdr_rem;
  logic           w_hdr_ok;

  assign w_word    = din[16*r_ch +: 16];
  assign w_hdr_rem = {1'b0, w_word[7:0]} + {8'd0, w_word[14]};

  // Search starts after the last grant; the just-served channel sits out one IDLE cycle
  // because its req still reflects the block that was just drained.
  always_comb begin
    w_hit  = 1'b0;
    w_pick = r_ch;
    w_idx  = '0;
    for (int unsigned i = 1; i <= NCHU; i++) begin
      w_idx = CW'((32'(r_ch) + i) % NCHU);
      if (!w_hit && req[w_idx] && !(r_excl && (w_idx == r_ch))) begin
        w_hit  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  // r_rem counts words not yet acknowledged; acks are issued one cycle ahead so the
  // COPY burst runs back-to-back behind the header.
  always_comb begin
    w_state  = r_state;
    w_ch     = r_ch;
    w_rem    = r_rem;
    w_ack    = '0;
    w_excl   = 1'b0;
    w_odata  = r_odata;
    w_ovalid = 1'b0;
    if (r_take && ((r_state != DEC) || w_hdr_ok)) begin
      w_odata  = w_word;
      w_ovalid = 1'b1;
    end
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_ch    = w_pick;
          w_state = HDR;
          if (!ofull) w_ack = NCH'(1) << w_pick;
        end
      end
      HDR: begin
        if (r_ack != '0)  w_state = DEC;
        else if (!ofull)  w_ack   = NCH'(1) << r_ch;
      end
      DEC: begin
        if (!w_hdr_ok) begin
          w_state = GAP;
        end else if (w_hdr_rem == '0) begin
          w_rem   = '0;
          w_state = GAP;
        end else begin
          w_state = COPY;
          if (!ofull) begin
            w_ack = NCH'(1) << r_ch;
            w_rem = w_hdr_rem - 9'd1;
          end else begin
            w_rem = w_hdr_rem;
          end
        end
      end
      COPY: begin
        if (r_rem == '0) begin
          w_state = GAP;
        end else if (!ofull) begin
          w_ack = NCH'(1) << r_ch;
          w_rem = r_rem - 9'd1;
        end
      end
      GAP: begin
        w_state = IDLE;
        w_excl  = 1'b1;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ch     <= CW'(NCH - 1);
      r_rem    <= '0;
      r_ack    <= '0;
      r_take   <= 1'b0;
      r_excl   <= 1'b0;
      r_odata  <= '0;
      r_ovalid <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_ch     <= w_ch;
      r_rem    <= w_rem;
      r_ack    <= w_ack;
      r_take   <= |r_ack;
      r_excl   <= w_excl;
      r_odata  <= w_odata;
      r_ovalid <= w_ovalid;
    end
  end

`ifdef CHKHDR_EN
  logic r_err;
  assign w_hdr_ok = w_word[15];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= (r_state == DEC) && r_take && !w_hdr_ok;
  end
  assign err = r_err;
`else
  assign w_hdr_ok = 1'b1;
  assign err      = 1'b0;
`endif

  assign ack    = r_ack;
  assign odata  = r_odata;
  assign ovalid = r_ovalid;
endmodule

// File: tb/tb_chan_arbiter.sv
// Self-checking bench for chan_arbiter: channel FIFO responders, a block-level stream model
// and a per-cycle compare process, plus literal per-scenario expectations.
`timescale 1ns/1ps
module tb_chan_arbiter;
  localparam int NCH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    ack;
  logic [16*NCH-1:0] din;
  logic [15:0]       odata;
  logic              ovalid;
  logic              ofull;
  logic              err;

  chan_arbiter #(.NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .din(din),
    .odata(odata), .ovalid(ovalid), .ofull(ofull), .err(err)
  );

  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] fq [NCH][$];
  logic [15:0] mq [NCH][$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          ack_cyc[$];
  int          ack_ch[$];
  int          left [NCH];
  int          m_last = NCH - 1;
  int          cyc = 0;
  int          err_seen = 0;
  bit          pf_emit = 1'b0;
  bit          pf_err = 1'b0;

  // Words in a block given its header; 0 means the header is rejected (one word consumed).
  function automatic int blk_total(input logic [15:0] h);
`ifdef CHKHDR_EN
    if (!h[15]) return 0;
`endif
    return int'(h[7:0]) + 1 + int'(h[14]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, want);
    end
  endtask

  task automatic load(input int c, input logic [15:0] words[$]);
    foreach (words[k]) begin
      fq[c].push_back(words[k]);
      mq[c].push_back(words[k]);
    end
  endtask

  // Round-robin over whole blocks from the last granted channel.
  task automatic model_run();
    bit found;
    int c, n;
    do begin
      found = 1'b0;
      for (int i = 1; i <= NCH && !found; i++) begin
        c = (m_last + i) % NCH;
        if (mq[c].size() != 0) begin
          found  = 1'b1;
          m_last = c;
          n = blk_total(mq[c][0]);
          if (n == 0) mq[c].delete(0);
          else for (int k = 0; k < n && mq[c].size() != 0; k++) exp_q.push_back(mq[c].pop_front());
        end
      end
    end while (found);
  endtask

  function automatic bit fifo_busy();
    for (int c = 0; c < NCH; c++) if (fq[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_busy()) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_drain: %0d words still expected, required 0", nm, exp_q.size());
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_got(input int target, input string nm);
    int n = 0;
    while (got_q.size() < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (got_q.size() < target) begin
      errors++;
      $display("FAIL %s_wait: got %0d words, required %0d", nm, got_q.size(), target);
    end
  endtask

  task automatic check_words(input string nm, input int o0, input logic [15:0] want[$]);
    chk({nm, "_count"}, got_q.size() - o0, want.size());
    for (int k = 0; k < want.size(); k++)
      if (o0 + k < got_q.size()) chk({nm, "_word"}, got_q[o0 + k], want[k]);
  endtask

  // Channel FIFO responders: an ack seen in cycle t presents the next word during t+1.
  initial begin : driver
    logic [NCH-1:0] a;
    logic [15:0]    w;
    req = '0;
    din = '0;
    forever begin
      @(negedge clk);
      a = ack;
      @(posedge clk);
      #1;
      cyc++;
      pf_emit = 1'b0;
      pf_err  = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (rst_n === 1'b1 && a[c] === 1'b1) begin
          ack_cyc.push_back(cyc);
          ack_ch.push_back(c);
          checks++;
          if (fq[c].size() == 0) begin
            errors++;
            $display("FAIL over_ack: ch%0d acked with 0 words queued, required at least 1", c);
          end else begin
            w = fq[c].pop_front();
            din[16*c +: 16] = w;
            if (left[c] == 0) begin
              if (blk_total(w) == 0) pf_err = 1'b1;
              else begin
                pf_emit = 1'b1;
                left[c] = blk_total(w) - 1;
              end
            end else begin
              pf_emit = 1'b1;
              left[c]--;
            end
          end
        end
        req[c] = (fq[c].size() != 0);
      end
    end
  end

  initial begin : compare
    bit          eo, ee;
    logic [15:0] e;
    eo = 1'b0;
    ee = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        eo = 1'b0;
        ee = 1'b0;
      end else begin
        checks++;
        if (ovalid !== eo) begin
          errors++;
          $display("FAIL ovalid_timing @cyc %0d: got %b, required %b", cyc, ovalid, eo);
        end
        checks++;
        if (err !== ee) begin
          errors++;
          $display("FAIL err_timing @cyc %0d: got %b, required %b", cyc, err, ee);
        end
        if (err === 1'b1) err_seen++;
        checks++;
        if ((ack & (ack - 1'b1)) !== '0) begin
          errors++;
          $display("FAIL ack_onehot @cyc %0d: got 0x%0h, required at most one bit", cyc, ack);
        end
        if (ovalid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL odata_extra @cyc %0d: got 0x%0h, required no word", cyc, odata);
          end else begin
            e = exp_q.pop_front();
            if (odata !== e) begin
              errors++;
              $display("FAIL odata @cyc %0d: got 0x%0h, required 0x%0h", cyc, odata, e);
            end
          end
          got_q.push_back(odata);
        end
        eo = pf_emit;
        ee = pf_err;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] lq[$];
    logic [15:0] lq2[$];
    int a0, o0, e0;
    rst_n = 1'b0;
    ofull = 1'b0;
    for (int c = 0; c < NCH; c++) left[c] = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_odata", odata, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single ch3 block, L=2
    a0 = ack_cyc.size(); o0 = got_q.size();
    lq = '{16'h8302, 16'h0011, 16'h0022};
    load(3, lq); model_run(); wait_drain("t28");
    chk("t28_acks", ack_cyc.size() - a0, 3);
    for (int k = 0; k < 3 && a0 + k < ack_ch.size(); k++) chk("t28_ack_ch", ack_ch[a0 + k], 3);
    if (ack_cyc.size() >= a0 + 3) begin
      chk("t28_ack_gap1", ack_cyc[a0 + 1] - ack_cyc[a0], 2);
      chk("t28_ack_gap2", ack_cyc[a0 + 2] - ack_cyc[a0 + 1], 1);
    end
    check_words("t28", o0, lq);

    // ch7 with two back-to-back L=0 blocks
    a0 = ack_cyc.size(); o0 = got_q.size();
    lq = '{16'h8700};
    load(7, lq); load(7, lq); model_run(); wait_drain("t31");
    chk("t31_acks", ack_cyc.size() - a0, 2);
    if (ack_cyc.size() >= a0 + 2) begin
      chk("t31_ack_gap", ack_cyc[a0 + 1] - ack_cyc[a0], 5);
      chk("t31_ch_a", ack_ch[a0], 7);
      chk("t31_ch_b", ack_ch[a0 + 1], 7);
    end
    lq2 = '{16'h8700, 16'h8700};
    check_words("t31", o0, lq2);

    // ch0 (T=1, L=1) and ch5 (L=0) pending together
    a0 = ack_cyc.size(); o0 = got_q.size();
    lq = '{16'hC001, 16'h8ABC, 16'h0123};
    load(0, lq);
    lq = '{16'h8500};
    load(5, lq); model_run(); wait_drain("t29");
    chk("t29_acks", ack_cyc.size() - a0, 4);
    if (ack_cyc.size() >= a0 + 4) begin
      chk("t29_first_ch", ack_ch[a0], 0);
      chk("t29_second_ch", ack_ch[a0 + 3], 5);
      chk("t29_grant_spacing", ack_cyc[a0 + 3] - ack_cyc[a0], 6);
    end
    lq2 = '{16'hC001, 16'h8ABC, 16'h0123, 16'h8500};
    check_words("t29", o0, lq2);

    // ch2 T=1 L=8 with a 4-cycle backpressure burst mid-block
    a0 = ack_cyc.size(); o0 = got_q.size();
    lq.delete();
    lq.push_back(16'hC208);
    for (int k = 0; k < 9; k++) lq.push_back(16'h2000 + 16'(k));
    load(2, lq); model_run();
    wait_got(o0 + 4, "t30");
    ofull = 1'b1;
    repeat (4) @(negedge clk);
    ofull = 1'b0;
    wait_drain("t30");
    chk("t30_acks", ack_cyc.size() - a0, 10);
    check_words("t30", o0, lq);

    // Reset in the middle of a ch1 L=20 block
    lq.delete();
    lq.push_back(16'h8114);
    for (int k = 0; k < 20; k++) lq.push_back(16'h1100 + 16'(k));
    load(1, lq); model_run();
    wait_got(got_q.size() + 5, "t32");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t32_rst_ack", ack, 0);
    chk("t32_rst_ovalid", ovalid, 0);
    chk("t32_rst_odata", odata, 0);
    chk("t32_rst_err", err, 0);
    for (int c = 0; c < NCH; c++) begin
      fq[c].delete();
      mq[c].delete();
      left[c] = 0;
    end
    exp_q.delete();
    m_last = NCH - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a0 = ack_cyc.size(); o0 = got_q.size();
    lq = '{16'h8F00};
    load(15, lq);
    lq = '{16'h8001, 16'h0A0A};
    load(0, lq); model_run(); wait_drain("t32b");
    if (ack_ch.size() > a0) chk("t32_restart_ch", ack_ch[a0], 0);
    else chk("t32_restart_acks", ack_cyc.size() - a0, 3);
    lq2 = '{16'h8001, 16'h0A0A, 16'h8F00};
    check_words("t32", o0, lq2);

`ifdef CHKHDR_EN
    // Rejected header on ch4, then ch5 is served
    a0 = ack_cyc.size(); o0 = got_q.size(); e0 = err_seen;
    lq = '{16'h1234};
    load(4, lq);
    lq = '{16'h8500};
    load(5, lq); model_run(); wait_drain("t33");
    chk("t33_err_pulses", err_seen - e0, 1);
    chk("t33_acks", ack_cyc.size() - a0, 2);
    if (ack_ch.size() >= a0 + 2) begin
      chk("t33_first_ch", ack_ch[a0], 4);
      chk("t33_second_ch", ack_ch[a0 + 1], 5);
    end
    lq2 = '{16'h8500};
    check_words("t33", o0, lq2);
`else
    e0 = err_seen;
    chk("no_err_pulses", e0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
